// File: rtl/fft_pingpong_ram_pkg.sv
// Shared types for the FFT ping-pong sample store: bank handoff FSM states
// and the supported read-latency range.
package fft_ram_pkg;

   typedef enum logic [1:0] {
      W_ONLY = 2'd0,
      BOTH   = 2'd1,
      STALL  = 2'd2
   } fsm_state_e;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 2;

endpackage

// File: rtl/fft_sdp_ram.sv
// Simple dual-port memory: one write port, one enabled and registered read port.
// The read register holds its value between reads so it can drive the output directly.
module fft_sdp_ram #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] wr_adr_i,
   input  logic [DW-1:0] wr_dat_i,
   input  logic          re_i,
   input  logic [AW-1:0] rd_adr_i,
   output logic [DW-1:0] rd_dat_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rd_dat_q;

   // Array itself is not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[wr_adr_i] <= wr_dat_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rd_dat_q <= '0;
      else if (re_i) rd_dat_q <= mem_q[rd_adr_i];
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample store: the FFT fills bank wr_bank while the host drains the
// other one; fft_done / wb_release hand frames across and guard against overwrite.
module fft_pingpong_ram
   import fft_ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fft_we,
   input  logic [ADDR_WIDTH-1:0] fft_adr,
   input  logic [DATA_WIDTH-1:0] fft_dat_i,
   input  logic                  fft_done,
   input  logic                  wb_re,
   input  logic [ADDR_WIDTH-1:0] wb_adr,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  wb_dat_vld,
   input  logic                  wb_release,
   output logic                  wr_bank,
   output logic                  rd_full,
   output logic                  wr_stall,
   output logic                  overrun,
   output logic [15:0]           frame_cnt
);

   // Out-of-range latencies fall back to the nearest supported value.
   localparam int RL = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;

   fsm_state_e    state_q, state_d;
   logic          wr_bank_q, wr_bank_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          overrun_q, overrun_d;
   logic [RL:1]   vld_pipe_q;
   logic          mem_we;
   logic [DATA_WIDTH-1:0] ram_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= W_ONLY;
         wr_bank_q   <= 1'b0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;
      case (state_q)
         W_ONLY: begin
            if (fft_done) begin
               wr_bank_d   = ~wr_bank_q;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = BOTH;
            end
         end
         BOTH: begin
            if (fft_done && wb_release) begin
               wr_bank_d   = ~wr_bank_q;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else if (fft_done) begin
               state_d = STALL;
            end else if (wb_release) begin
               state_d = W_ONLY;
            end
         end
         STALL: begin
            if (wb_release) begin
               wr_bank_d   = ~wr_bank_q;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = BOTH;
            end
            // FFT strobes seen in STALL are lost even if a release lands the same cycle.
            if (fft_we || fft_done) overrun_d = 1'b1;
         end
         default: state_d = W_ONLY;
      endcase
   end

   assign mem_we = fft_we && (state_q != STALL);

   fft_sdp_ram #(
      .AW (ADDR_WIDTH + 1),
      .DW (DATA_WIDTH)
   ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .we_i     (mem_we),
      .wr_adr_i ({wr_bank_q, fft_adr}),
      .wr_dat_i (fft_dat_i),
      .re_i     (wb_re),
      .rd_adr_i ({~wr_bank_q, wb_adr}),
      .rd_dat_o (ram_dat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
      end else begin
         vld_pipe_q[1] <= wb_re;
         for (int k = 2; k <= RL; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      end
   end

   generate
      if (RL == 2) begin : g_oreg
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                dout_q <= '0;
            else if (vld_pipe_q[1]) dout_q <= ram_dat;
         end
         assign wb_dat_o = dout_q;
      end else begin : g_direct
         assign wb_dat_o = ram_dat;
      end
   endgenerate

   assign wb_dat_vld = vld_pipe_q[RL];
   assign wr_bank    = wr_bank_q;
   assign rd_full    = (state_q != W_ONLY);
   assign wr_stall   = (state_q == STALL);
   assign overrun    = overrun_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench: one instance at read latency 1 and one at 2 share all inputs,
// so every handoff scenario is checked against both read pipelines.
module tb_fft_pingpong_ram;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          fft_we, fft_done, wb_re, wb_release;
   logic [AW-1:0] fft_adr, wb_adr;
   logic [DW-1:0] fft_dat_i;

   logic [DW-1:0] dat1, dat2;
   logic          vld1, vld2;
   logic          bank1, full1, stall1, ovr1;
   logic          bank2, full2, stall2, ovr2;
   logic [15:0]   cnt1, cnt2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fft_pingpong_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .fft_we(fft_we), .fft_adr(fft_adr), .fft_dat_i(fft_dat_i),
      .fft_done(fft_done), .wb_re(wb_re), .wb_adr(wb_adr), .wb_dat_o(dat1),
      .wb_dat_vld(vld1), .wb_release(wb_release), .wr_bank(bank1), .rd_full(full1),
      .wr_stall(stall1), .overrun(ovr1), .frame_cnt(cnt1)
   );

   fft_pingpong_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .fft_we(fft_we), .fft_adr(fft_adr), .fft_dat_i(fft_dat_i),
      .fft_done(fft_done), .wb_re(wb_re), .wb_adr(wb_adr), .wb_dat_o(dat2),
      .wb_dat_vld(vld2), .wb_release(wb_release), .wr_bank(bank2), .rd_full(full2),
      .wr_stall(stall2), .overrun(ovr2), .frame_cnt(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Status of both instances must agree with the expected handoff state.
   task automatic chk_status(input string tag, input logic bank, input logic full,
                             input logic stall, input logic ovr, input logic [15:0] cnt);
      chk({tag, ".wr_bank1"},  32'(bank1),  32'(bank));
      chk({tag, ".rd_full1"},  32'(full1),  32'(full));
      chk({tag, ".wr_stall1"}, 32'(stall1), 32'(stall));
      chk({tag, ".overrun1"},  32'(ovr1),   32'(ovr));
      chk({tag, ".frame_cnt1"}, 32'(cnt1),  32'(cnt));
      chk({tag, ".wr_bank2"},  32'(bank2),  32'(bank));
      chk({tag, ".frame_cnt2"}, 32'(cnt2),  32'(cnt));
      chk({tag, ".wr_stall2"}, 32'(stall2), 32'(stall));
   endtask

   initial begin
      rst = 1'b1; fft_we = 1'b0; fft_done = 1'b0; wb_re = 1'b0; wb_release = 1'b0;
      fft_adr = '0; wb_adr = '0; fft_dat_i = '0;
      tick(); tick();
      chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk("reset.dat1", dat1, 32'h0);
      chk("reset.dat2", dat2, 32'h0);
      chk("reset.vld1", 32'(vld1), 32'h0);
      chk("reset.vld2", 32'(vld2), 32'h0);
      rst = 1'b0;
      tick();

      // Idle read in W_ONLY: valid still follows wb_re at each latency
      wb_re = 1'b1; wb_adr = 10'd0;
      tick();
      wb_re = 1'b0;
      chk("idle.vld1_t1", 32'(vld1), 32'h1);
      chk("idle.vld2_t1", 32'(vld2), 32'h0);
      tick();
      chk("idle.vld1_t2", 32'(vld1), 32'h0);
      chk("idle.vld2_t2", 32'(vld2), 32'h1);
      tick();
      chk("idle.vld2_t3", 32'(vld2), 32'h0);

      // Frame 1 into bank 0; last word coincides with fft_done (pre-swap bank)
      for (int a = 0; a < 1024; a++) begin
         fft_we = 1'b1; fft_adr = AW'(a); fft_dat_i = 32'(a) + 32'h100;
         fft_done = (a == 1023);
         tick();
      end
      fft_we = 1'b0; fft_done = 1'b0;
      chk_status("frame1", 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);

      // Back-to-back reads of bank 0
      wb_re = 1'b1; wb_adr = 10'd5;
      tick();
      chk("rd5.dat1", dat1, 32'h105);
      chk("rd5.vld1", 32'(vld1), 32'h1);
      chk("rd5.vld2", 32'(vld2), 32'h0);
      wb_adr = 10'd1023;
      tick();
      wb_re = 1'b0;
      chk("rd1023.dat1", dat1, 32'h4FF);
      chk("rd5.dat2", dat2, 32'h105);
      chk("rd5.vld2b", 32'(vld2), 32'h1);
      tick();
      chk("hold.vld1", 32'(vld1), 32'h0);
      chk("hold.dat1", dat1, 32'h4FF);
      chk("rd1023.dat2", dat2, 32'h4FF);
      chk("rd1023.vld2", 32'(vld2), 32'h1);
      tick();
      chk("hold.vld2", 32'(vld2), 32'h0);
      chk("hold.dat2", dat2, 32'h4FF);

      // Frame 2 into bank 1, then fft_done with host still busy -> STALL
      for (int a = 0; a < 1024; a++) begin
         fft_we = 1'b1; fft_adr = AW'(a); fft_dat_i = 32'(a) + 32'h200;
         tick();
      end
      fft_we = 1'b0;
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      chk_status("stall", 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);

      // Write attempt while stalled is dropped and flags overrun
      fft_we = 1'b1; fft_adr = 10'd0; fft_dat_i = 32'hDEAD;
      tick();
      fft_we = 1'b0;
      chk_status("ovr", 1'b1, 1'b1, 1'b1, 1'b1, 16'd1);
      wb_re = 1'b1; wb_adr = 10'd0;
      tick(); wb_re = 1'b0; tick();
      chk("stall.bank0_adr0_1", dat1, 32'h100);
      chk("stall.bank0_adr0_2", dat2, 32'h100);

      // Release from STALL hands bank 1 over
      wb_release = 1'b1;
      tick();
      wb_release = 1'b0;
      chk_status("rel_stall", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
      wb_re = 1'b1; wb_adr = 10'd0;
      tick(); wb_adr = 10'd7; tick(); wb_re = 1'b0;
      chk("bank1_adr0.dat2", dat2, 32'h200);
      chk("bank1_adr7.dat1", dat1, 32'h207);
      tick();
      chk("bank1_adr7.dat2", dat2, 32'h207);

      // Simultaneous done + release in BOTH: single swap, stays BOTH
      fft_done = 1'b1; wb_release = 1'b1;
      tick();
      fft_done = 1'b0; wb_release = 1'b0;
      chk_status("swap", 1'b1, 1'b1, 1'b0, 1'b1, 16'd3);
      wb_re = 1'b1; wb_adr = 10'd3;
      tick(); wb_re = 1'b0; tick();
      chk("swap.rd3_1", dat1, 32'h103);
      chk("swap.rd3_2", dat2, 32'h103);

      // Release alone in BOTH -> W_ONLY; release in W_ONLY ignored
      wb_release = 1'b1;
      tick();
      chk_status("rel_both", 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
      tick();
      wb_release = 1'b0;
      chk_status("rel_wonly", 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);

      // Counter wrap: one done from W_ONLY, then done+release every cycle
      fft_done = 1'b1;
      tick();
      chk_status("wrap_start", 1'b0, 1'b1, 1'b0, 1'b1, 16'd4);
      wb_release = 1'b1;
      for (int i = 0; i < 65531; i++) tick();
      chk("wrap.ffff", 32'(cnt1), 32'h0000FFFF);
      tick();
      fft_done = 1'b0; wb_release = 1'b0;
      chk_status("wrap_zero", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);

      // Reset during an in-flight latency-2 read
      wb_re = 1'b1; wb_adr = 10'd9;
      tick();
      wb_re = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstmid.vld2", 32'(vld2), 32'h0);
      chk("rstmid.dat2", dat2, 32'h0);
      chk("rstmid.dat1", dat1, 32'h0);
      tick();
      chk("rstmid.vld2_next", 32'(vld2), 32'h0);
      chk_status("rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
      tick();
      chk("rstmid.vld2_after", 32'(vld2), 32'h0);
      chk("rstmid.dat2_after", dat2, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_pingpong_ram.md
Name: fft_pingpong_ram

Overview:
- Double-buffered (ping-pong) sample store between the FFT core (write side) and the Wishbone host (read side) in the WISHBONE_FFT subsystem.
- Successor to the single-bank simple dual-port RAM: parametrised width, depth and read latency, with two banks and an explicit frame handoff.
- The FFT fills one bank while the host drains the other. A done/release handshake swaps the banks, and stall/overrun status protects frames.

Parameters:
- ADDR_WIDTH, 10, address bits per bank (bank depth = 2**ADDR_WIDTH words).
- DATA_WIDTH, 32, word width in bits.
- READ_LATENCY, 1, clocks from wb_re to wb_dat_o valid. Legal values are 1 or 2; 2 adds an output register.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fft_we  in  1  write strobe into the current write bank.
- fft_adr  in  ADDR_WIDTH  write address within the write bank.
- fft_dat_i  in  DATA_WIDTH  write data.
- fft_done  in  1  one-cycle pulse: the write bank holds a complete frame.
- wb_re  in  1  read strobe from the current read bank.
- wb_adr  in  ADDR_WIDTH  read address within the read bank.
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_dat_vld  out  1  wb_dat_o is valid this cycle.
- wb_release  in  1  one-cycle pulse: the host has finished with the read bank.
- wr_bank  out  1  index of the bank the FFT currently writes. The read bank is always the inverse of wr_bank.
- rd_full  out  1  the read bank holds an unreleased frame.
- wr_stall  out  1  both banks are full; the FFT must not write.
- overrun  out  1  sticky error flag, cleared only by rst.
- frame_cnt  out  16  number of frames handed to the host; wraps.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - wr_bank=0, rd_full=0, wr_stall=0, overrun=0, frame_cnt=0.
  - wb_dat_o=0, wb_dat_vld=0; read pipeline flushed.
  - FSM goes to W_ONLY. Memory contents are not reset.
- Storage: one memory of 2*2**ADDR_WIDTH words.
  - Write physical address = {wr_bank, fft_adr}.
  - Read physical address = {~wr_bank, wb_adr}, with the bank sampled at the wb_re cycle.
- Reads and writes always target different banks, so no read-during-write collision and no bypass is needed.
- Read timing:
  - wb_dat_vld is wb_re delayed by READ_LATENCY cycles.
  - wb_dat_o holds its last value when not valid.
  - Reads are permitted in every state. In W_ONLY the read returns stale content and still asserts vld.
- Write timing: when fft_we=1 and not in STALL, mem[{wr_bank,fft_adr}] is written at the clock edge.
- FSM states and transitions:
  - W_ONLY (read bank empty):
    - fft_done: toggle wr_bank, rd_full=1, frame_cnt+1, go to BOTH.
    - wb_release: ignored.
  - BOTH (writing one bank, the other full):
    - fft_done and wb_release together: toggle wr_bank, rd_full stays 1, frame_cnt+1, stay in BOTH.
    - fft_done only: go to STALL; wr_bank does not toggle.
    - wb_release only: rd_full=0, go to W_ONLY.
  - STALL (both banks full, wr_stall=1):
    - wb_release: toggle wr_bank (the released bank becomes the write bank), rd_full=1, frame_cnt+1, go to BOTH.
    - fft_we or fft_done: the write is dropped and overrun is set (sticky).
    - If wb_release coincides with fft_we or fft_done, the release is processed and the FFT strobe is still treated as occurring in STALL: dropped, overrun set.
- fft_we together with fft_done: the write lands in the pre-swap bank.
- Status encoding:
  - wr_stall is decoded from the state register only (no combinational path from inputs).
  - rd_full=1 in BOTH and STALL.
- frame_cnt wraps from 16'hFFFF to 0.
- rst asserted mid-read drops any in-flight read; vld is not asserted for it.

Decomposition:
- Package fft_ram_pkg: FSM state enum (W_ONLY, BOTH, STALL) and the legal READ_LATENCY values.
- One sub-module, fft_sdp_ram: simple dual-port memory with one write port and one registered read port, parametrised by address and data width, inferable as block RAM.
- Top level holds the FSM, the bank pointer, the optional output register, the valid pipeline and the counters.

Test Plan:
- Reset then idle -> all outputs 0, wr_bank=0, state W_ONLY; wb_re yields wb_dat_vld after READ_LATENCY cycles.
- Write 0..1023 with data=adr+0x100, then pulse fft_done -> wr_bank=1, rd_full=1, frame_cnt=1; reading adr 5 returns 0x105 with correct latency, for both READ_LATENCY=1 and 2.
- In BOTH, fill bank 1 and pulse fft_done -> wr_stall=1. A further fft_we to adr 0 with 0xDEAD -> overrun=1 and bank 0 adr 0 still 0x100. Then wb_release -> wr_bank=0, rd_full=1, wr_stall=0, frame_cnt=2.
- In BOTH, pulse fft_done and wb_release in the same cycle -> wr_bank toggles, stays in BOTH, rd_full=1, frame_cnt increments once.
- wb_release in W_ONLY -> no state change. In BOTH, wb_release alone -> rd_full=0, W_ONLY.
- Assert rst while a READ_LATENCY=2 read is in flight -> wb_dat_vld stays 0 and wb_dat_o=0 immediately. 65536 handoffs -> frame_cnt wraps to 0.
